mcu_mem_port: RTL and testbench

Responder for the MCU memory-request handshake. Accepts single-cycle read/write request pulses with a 24-bit address from the MCU command interpreter. Performs each access on the external cartridge SRAM/ROM bus during windows granted by the SNES-side arbiter. Returns read data with a one-cycle ready pulse whose rising edge advances the requester's auto-incrementing address.

---
 rtl/mcu_mem_pkg.sv | 20 ++
 rtl/mcu_mem_req_buf.sv | 41 ++++
 rtl/mcu_mem_port.sv | 167 ++++++++++++++++
 tb/tb_mcu_mem_port.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mcu_mem_pkg.sv
// Shared types and constants for the MCU memory-request port.
package mcu_mem_pkg;

    localparam int unsigned MCU_MEM_ADDR_W       = 24;
    localparam int unsigned MCU_MEM_WAIT_CYC_MIN = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLOT,
        ACCESS,
        DONE
    } mcu_mem_state_e;

    typedef struct packed {
        logic                      is_write;
        logic [MCU_MEM_ADDR_W-1:0] addr;
        logic [7:0]                wdata;
    } mcu_mem_req_t;

endpackage

// File: rtl/mcu_mem_req_buf.sv
// One-deep request holding register; a load in the same cycle as a pop wins.
module mcu_mem_req_buf
    import mcu_mem_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         pop_i,
    input  mcu_mem_req_t req_i,
    output logic         full_o,
    output mcu_mem_req_t req_o
);

    logic         full_q, full_d;
    mcu_mem_req_t req_q, req_d;

    always_comb begin
        full_d = full_q;
        req_d  = req_q;
        if (load_i) begin
            full_d = 1'b1;
            req_d  = req_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

    assign full_o = full_q;
    assign req_o  = req_q;

endmodule

// File: rtl/mcu_mem_port.sv
// MCU memory-request responder: runs one bus access per request inside arbiter slots.
// Define MCU_MEM_PORT_QUEUE_EN to add a one-deep pending request buffer.
module mcu_mem_port
    import mcu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = MCU_MEM_ADDR_W,
    parameter int unsigned WAIT_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mcu_rrq,
    input  logic              mcu_wrq,
    input  logic [ADDR_W-1:0] mcu_addr,
    input  logic [7:0]        mcu_wdata,
    output logic [7:0]        mcu_rdata,
    output logic              mcu_rq_rdy,
    input  logic              slot_en,
    output logic              busy,
    output logic              err_overrun,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_dout_en,
    input  logic [7:0]        ram_din,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    localparam int unsigned WAIT_EFF = (WAIT_CYC < MCU_MEM_WAIT_CYC_MIN) ? MCU_MEM_WAIT_CYC_MIN : WAIT_CYC;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_EFF - 1);

    mcu_mem_state_e state_q, state_d;
    mcu_mem_req_t   act_q, act_d, new_s;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           new_req, drop;
    logic           rdy_q, oe_n_q, we_n_q, dout_en_q;
    logic [7:0]     dout_q;
    logic [ADDR_W-1:0] addr_q;

    assign new_req        = mcu_rrq | mcu_wrq;
    assign new_s.is_write = mcu_wrq;
    assign new_s.addr     = MCU_MEM_ADDR_W'(mcu_addr);
    assign new_s.wdata    = mcu_wdata;

`ifdef MCU_MEM_PORT_QUEUE_EN
    logic         pend_full, pend_load, pend_pop;
    mcu_mem_req_t pend_req;

    mcu_mem_req_buf u_req_buf (
        .clk    (clk),
        .rst    (rst),
        .load_i (pend_load),
        .pop_i  (pend_pop),
        .req_i  (new_s),
        .full_o (pend_full),
        .req_o  (pend_req)
    );
`endif

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        drop    = mcu_rrq & mcu_wrq;
`ifdef MCU_MEM_PORT_QUEUE_EN
        pend_load = 1'b0;
        pend_pop  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (new_req) begin
                    act_d   = new_s;
                    state_d = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (slot_en) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!act_q.is_write) rdata_d = ram_din;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef MCU_MEM_PORT_QUEUE_EN
                // A request arriving in DONE with an empty buffer goes straight to active.
                if (pend_full) begin
                    act_d     = pend_req;
                    pend_pop  = 1'b1;
                    pend_load = new_req;
                    state_d   = WAIT_SLOT;
                end else if (new_req) begin
                    act_d   = new_s;
                    state_d = WAIT_SLOT;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef MCU_MEM_PORT_QUEUE_EN
        if (new_req && (state_q == WAIT_SLOT || state_q == ACCESS)) begin
            if (pend_full) drop = 1'b1;
            else           pend_load = 1'b1;
        end
`else
        if (new_req && state_q != IDLE) drop = 1'b1;
`endif
        err_d = (err_q & ~err_clr) | drop;
    end

    // Strobes are decoded from next-state values so they come straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            act_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dout_en_q <= 1'b0;
            dout_q    <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rdy_q     <= (state_d == DONE);
            oe_n_q    <= !(state_d == ACCESS && !act_d.is_write);
            we_n_q    <= !(state_d == ACCESS && act_d.is_write && cnt_d != 4'd0);
            dout_en_q <= (state_d == WAIT_SLOT || state_d == ACCESS) && act_d.is_write;
            if ((state_d == WAIT_SLOT || state_d == ACCESS) && act_d.is_write)
                dout_q <= act_d.wdata;
            if (state_d == WAIT_SLOT || state_d == ACCESS)
                addr_q <= ADDR_W'(act_d.addr);
        end
    end

`ifdef MCU_MEM_PORT_QUEUE_EN
    assign busy = (state_q != IDLE) | pend_full;
`else
    assign busy = (state_q != IDLE);
`endif

    assign mcu_rdata   = rdata_q;
    assign mcu_rq_rdy  = rdy_q;
    assign err_overrun = err_q;
    assign ram_addr    = addr_q;
    assign ram_dout    = dout_q;
    assign ram_dout_en = dout_en_q;
    assign ram_oe_n    = oe_n_q;
    assign ram_we_n    = we_n_q;

endmodule

// File: tb/tb_mcu_mem_port.sv
// Directed bench for mcu_mem_port; cycle c is the clock period after the c-th rising edge
// following the request, inputs change and outputs are observed on the falling edge.
module tb_mcu_mem_port;

`ifdef MCU_MEM_PORT_QUEUE_EN
    localparam bit Q = 1'b1;
`else
    localparam bit Q = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, mcu_rrq, mcu_wrq, slot_en, err_clr;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_wdata, ram_din;
    logic [7:0]  mcu_rdata, ram_dout;
    logic        mcu_rq_rdy, busy, err_overrun, ram_dout_en, ram_oe_n, ram_we_n;
    logic [23:0] ram_addr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mcu_mem_port #(.ADDR_W(24), .WAIT_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mcu_rrq     (mcu_rrq),
        .mcu_wrq     (mcu_wrq),
        .mcu_addr    (mcu_addr),
        .mcu_wdata   (mcu_wdata),
        .mcu_rdata   (mcu_rdata),
        .mcu_rq_rdy  (mcu_rq_rdy),
        .slot_en     (slot_en),
        .busy        (busy),
        .err_overrun (err_overrun),
        .err_clr     (err_clr),
        .ram_addr    (ram_addr),
        .ram_dout    (ram_dout),
        .ram_dout_en (ram_dout_en),
        .ram_din     (ram_din),
        .ram_oe_n    (ram_oe_n),
        .ram_we_n    (ram_we_n)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s c%0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag, input int c);
        chk({tag, " oe_n"}, c, 32'(ram_oe_n), 32'd1);
        chk({tag, " we_n"}, c, 32'(ram_we_n), 32'd1);
        chk({tag, " dout_en"}, c, 32'(ram_dout_en), 32'd0);
        chk({tag, " addr"}, c, 32'(ram_addr), 32'd0);
        chk({tag, " dout"}, c, 32'(ram_dout), 32'd0);
        chk({tag, " rdata"}, c, 32'(mcu_rdata), 32'd0);
        chk({tag, " rdy"}, c, 32'(mcu_rq_rdy), 32'd0);
        chk({tag, " busy"}, c, 32'(busy), 32'd0);
        chk({tag, " err"}, c, 32'(err_overrun), 32'd0);
    endtask

    initial begin
        rst = 1'b1; mcu_rrq = 1'b0; mcu_wrq = 1'b0; mcu_addr = '0; mcu_wdata = '0;
        slot_en = 1'b0; ram_din = '0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset", 0);
        rst = 1'b0;

        // Read at 0x123456, slot always granted.
        slot_en = 1'b1; ram_din = 8'hA5; mcu_addr = 24'h123456; mcu_rrq = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            mcu_rrq = 1'b0;
            chk("rd oe_n", c, 32'(ram_oe_n), (c >= 2 && c <= 5) ? 32'd0 : 32'd1);
            chk("rd we_n", c, 32'(ram_we_n), 32'd1);
            chk("rd rdy", c, 32'(mcu_rq_rdy), (c == 6) ? 32'd1 : 32'd0);
            chk("rd busy", c, 32'(busy), (c <= 6) ? 32'd1 : 32'd0);
            if (c == 2) chk("rd addr", c, 32'(ram_addr), 32'h123456);
            if (c == 6) chk("rd rdata", c, 32'(mcu_rdata), 32'hA5);
        end

        // Write 0x3C at 0x7F0010.
        mcu_addr = 24'h7F0010; mcu_wdata = 8'h3C; mcu_wrq = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            mcu_wrq = 1'b0;
            chk("wr we_n", c, 32'(ram_we_n), (c >= 2 && c <= 4) ? 32'd0 : 32'd1);
            chk("wr oe_n", c, 32'(ram_oe_n), 32'd1);
            chk("wr dout_en", c, 32'(ram_dout_en), (c >= 1 && c <= 5) ? 32'd1 : 32'd0);
            chk("wr rdy", c, 32'(mcu_rq_rdy), (c == 6) ? 32'd1 : 32'd0);
            if (c == 2) chk("wr addr", c, 32'(ram_addr), 32'h7F0010);
            if (c == 5) chk("wr dout", c, 32'(ram_dout), 32'h3C);
            if (c == 7) chk("wr rdata kept", c, 32'(mcu_rdata), 32'hA5);
        end

        // Read with grant withheld for 10 cycles.
        slot_en = 1'b0; ram_din = 8'h5A; mcu_addr = 24'h000ABC; mcu_rrq = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            mcu_rrq = 1'b0;
            chk("st oe_n", c, 32'(ram_oe_n), (c >= 12 && c <= 15) ? 32'd0 : 32'd1);
            chk("st we_n", c, 32'(ram_we_n), 32'd1);
            chk("st rdy", c, 32'(mcu_rq_rdy), (c == 16) ? 32'd1 : 32'd0);
            chk("st busy", c, 32'(busy), (c <= 16) ? 32'd1 : 32'd0);
            if (c == 5) chk("st addr", c, 32'(ram_addr), 32'h000ABC);
            if (c == 16) chk("st rdata", c, 32'(mcu_rdata), 32'h5A);
            if (c == 11) slot_en = 1'b1;
        end

        // Simultaneous read and write: only the write runs, overrun flagged, then cleared.
        mcu_addr = 24'h000100; mcu_wdata = 8'h77; mcu_rrq = 1'b1; mcu_wrq = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            mcu_rrq = 1'b0; mcu_wrq = 1'b0;
            chk("sim we_n", c, 32'(ram_we_n), (c >= 2 && c <= 4) ? 32'd0 : 32'd1);
            chk("sim oe_n", c, 32'(ram_oe_n), 32'd1);
            chk("sim rdy", c, 32'(mcu_rq_rdy), (c == 6) ? 32'd1 : 32'd0);
            chk("sim err", c, 32'(err_overrun), (c <= 7) ? 32'd1 : 32'd0);
            if (c == 4) chk("sim dout", c, 32'(ram_dout), 32'h77);
            if (c == 8) chk("sim rdata kept", c, 32'(mcu_rdata), 32'h5A);
            err_clr = (c == 7);
        end

        // Back-to-back reads at cycles 0, 3, 4; clear collides with the cycle-4 drop.
        ram_din = 8'h3D; mcu_addr = 24'h000200; mcu_rrq = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk("b2b rdy", c, 32'(mcu_rq_rdy), (c == 6 || (Q && c == 12)) ? 32'd1 : 32'd0);
            chk("b2b oe_n", c, 32'(ram_oe_n),
                ((c >= 2 && c <= 5) || (Q && c >= 8 && c <= 11)) ? 32'd0 : 32'd1);
            chk("b2b busy", c, 32'(busy), (c <= (Q ? 12 : 6)) ? 32'd1 : 32'd0);
            chk("b2b err", c, 32'(err_overrun), (c <= 3) ? 32'd0 : (c == 4) ? 32'(!Q) : 32'd1);
            chk("b2b excl", c, 32'(ram_oe_n | ram_we_n), 32'd1);
            mcu_rrq  = (c == 3 || c == 4);
            mcu_addr = (c == 3) ? 24'h000300 : 24'h000400;
            err_clr  = (c == 4);
        end

        // Reset during ACCESS with a second request offered.
        ram_din = 8'h11; mcu_addr = 24'h000500; mcu_rrq = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("rst pre oe_n", c, 32'(ram_oe_n), 32'd0);
                chk("rst pre err", c, 32'(err_overrun), 32'd1);
            end
            if (c >= 4) chk_reset_vals("rst post", c);
            mcu_rrq = (c == 2);
            rst     = (c == 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
